// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - shared FSM encoding and protocol constants for the PSX pad poller
package psx_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SELECT,
        SHIFT,
        WAIT_ACK,
        GAP,
        DESELECT
    } psx_state_e;

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_POLL   = 8'h42;
    localparam logic [7:0] CMD_IDLE   = 8'h00;
    localparam logic [7:0] ID_DIGITAL = 8'h41;
    localparam logic [7:0] ID_ANALOG  = 8'h73;
    localparam logic [7:0] MARKER     = 8'h5A;

    // Command byte sent in position idx of a poll frame.
    function automatic logic [7:0] cmd_for_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_for_byte = CMD_START;
            4'd1:    cmd_for_byte = CMD_POLL;
            default: cmd_for_byte = CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// rtl/psx_byte_xfer.sv - one-byte full-duplex serializer on the pad bus
// Ports: clk/rst; start+tx_byte launch a byte; data is the pad reply line;
// psx_clk/cmd drive the bus (idle high); rx_byte holds the received byte,
// valid when done pulses for one cycle.
module psx_byte_xfer #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       data,
    output logic       psx_clk,
    output logic       cmd,
    output logic [7:0] rx_byte,
    output logic       done
);
    localparam logic [31:0] DIV_M1 = 32'(CLK_DIV - 1);

    logic        busy_q, busy_d;
    logic [31:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        psx_clk_q, psx_clk_d;
    logic        cmd_q, cmd_d;
    logic        done_q, done_d;

    // psx_clk_q doubles as the phase flag: low phase ends with a data sample,
    // high phase ends with either the next falling edge or byte completion.
    always_comb begin
        busy_d    = busy_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        psx_clk_d = psx_clk_q;
        cmd_d     = cmd_q;
        done_d    = 1'b0;
        if (!busy_q) begin
            if (start) begin
                busy_d    = 1'b1;
                psx_clk_d = 1'b0;
                cmd_d     = tx_byte[0];
                tx_d      = {1'b1, tx_byte[7:1]};
                div_d     = '0;
                bit_d     = '0;
            end
        end else if (div_q != DIV_M1) begin
            div_d = div_q + 32'd1;
        end else begin
            div_d = '0;
            if (!psx_clk_q) begin
                psx_clk_d = 1'b1;
                rx_d      = {data, rx_q[7:1]};
            end else if (bit_q == 3'd7) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cmd_d  = 1'b1;
            end else begin
                psx_clk_d = 1'b0;
                cmd_d     = tx_q[0];
                tx_d      = {1'b1, tx_q[7:1]};
                bit_d     = bit_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '1;
            rx_q      <= '1;
            psx_clk_q <= 1'b1;
            cmd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            psx_clk_q <= psx_clk_d;
            cmd_q     <= cmd_d;
            done_q    <= done_d;
        end
    end

    assign psx_clk = psx_clk_q;
    assign cmd     = cmd_q;
    assign rx_byte = rx_q;
    assign done    = done_q;

endmodule

// File: rtl/psx_multi_console.sv
// rtl/psx_multi_console.sv - periodic poller for up to four PSX pads on a shared bus
// Ports: clk/rst (sync, active high); data/ack from the selected pad;
// psx_clk/cmd/att drive the bus; button_state/analog_state/pad_present/
// pad_analog hold per-pad results; frame_done pulses after the last pad.
module psx_multi_console
    import psx_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int CLK_DIV     = 5,
    parameter int BOOT_TIME   = 100000,
    parameter int POLL_PERIOD = 160000,
    parameter int ACK_TIMEOUT = 100,
    parameter int ATT_SETUP   = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data,
    input  logic                  ack,
    output logic                  psx_clk,
    output logic                  cmd,
    output logic [NUM_PADS-1:0]   att,
    output logic [16*NUM_PADS-1:0] button_state,
    output logic [32*NUM_PADS-1:0] analog_state,
    output logic [NUM_PADS-1:0]   pad_present,
    output logic [NUM_PADS-1:0]   pad_analog,
    output logic                  frame_done
);
    localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam logic [PAD_W-1:0] LAST_PAD  = PAD_W'(NUM_PADS - 1);
    localparam logic [31:0]      BOOT_M1   = 32'(BOOT_TIME - 1);
    localparam logic [31:0]      PERIOD_M1 = 32'(POLL_PERIOD - 1);
    localparam logic [31:0]      ACK_M1    = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0]      SETUP_M1  = 32'(ATT_SETUP - 1);

    psx_state_e state_q, state_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] tmr_q, tmr_d;
    logic [PAD_W-1:0] pad_q, pad_d;
    logic [3:0]  byte_q, byte_d, nbytes_q, nbytes_d;
    logic [15:0] btn_buf_q, btn_buf_d;
    logic [31:0] ana_buf_q, ana_buf_d;
    logic        is_analog_q, is_analog_d;
    logic [NUM_PADS-1:0]    att_q, att_d, present_q, present_d, pad_analog_q, pad_analog_d;
    logic [16*NUM_PADS-1:0] button_q, button_d;
    logic [32*NUM_PADS-1:0] analog_q, analog_d;
    logic        frame_done_q, frame_done_d;

    logic       xfer_start, xfer_done, commit, commit_ok, abort;
    logic [7:0] xfer_rx;

    psx_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start   (xfer_start),
        .tx_byte (cmd_for_byte(byte_q)),
        .data    (data),
        .psx_clk (psx_clk),
        .cmd     (cmd),
        .rx_byte (xfer_rx),
        .done    (xfer_done)
    );

    always_comb begin
        state_d      = state_q;
        // Frame counter saturates so a frame overrunning the period starts the next one at once.
        frame_cnt_d  = (frame_cnt_q >= PERIOD_M1) ? PERIOD_M1 : frame_cnt_q + 32'd1;
        tmr_d        = tmr_q + 32'd1;
        pad_d        = pad_q;
        byte_d       = byte_q;
        nbytes_d     = nbytes_q;
        btn_buf_d    = btn_buf_q;
        ana_buf_d    = ana_buf_q;
        is_analog_d  = is_analog_q;
        att_d        = att_q;
        present_d    = present_q;
        pad_analog_d = pad_analog_q;
        button_d     = button_q;
        analog_d     = analog_q;
        frame_done_d = 1'b0;
        xfer_start   = 1'b0;
        commit       = 1'b0;
        commit_ok    = 1'b0;
        abort        = 1'b0;
        case (state_q)
            BOOT: begin
                frame_cnt_d = frame_cnt_q + 32'd1;
                if (frame_cnt_q == BOOT_M1) begin
                    state_d     = IDLE;
                    frame_cnt_d = PERIOD_M1;  // first frame starts right after boot
                end
            end
            IDLE: begin
                if (frame_cnt_q >= PERIOD_M1) begin
                    state_d     = SELECT;
                    frame_cnt_d = '0;
                    pad_d       = '0;
                end
            end
            SELECT, GAP: begin
                if (tmr_q == SETUP_M1) begin
                    xfer_start = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer_done) begin
                    tmr_d = '0;
                    case (byte_q)
                        4'd1: begin
                            is_analog_d = (xfer_rx == ID_ANALOG);
                            // Only 0x41/0x73 survive, so ID[2:0] suffices for 2*ID[3:0].
                            nbytes_d    = 4'd3 + {xfer_rx[2:0], 1'b0};
                            abort       = (xfer_rx != ID_DIGITAL) && (xfer_rx != ID_ANALOG);
                        end
                        4'd2: abort = (xfer_rx != MARKER);
                        4'd3: btn_buf_d[7:0]   = xfer_rx;
                        4'd4: btn_buf_d[15:8]  = xfer_rx;
                        4'd5: ana_buf_d[7:0]   = xfer_rx;
                        4'd6: ana_buf_d[15:8]  = xfer_rx;
                        4'd7: ana_buf_d[23:16] = xfer_rx;
                        4'd8: ana_buf_d[31:24] = xfer_rx;
                        default: ;
                    endcase
                    if (abort) begin
                        commit = 1'b1;
                    end else if (byte_q == nbytes_q - 4'd1) begin
                        commit    = 1'b1;
                        commit_ok = 1'b1;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (!ack) begin
                    state_d = GAP;
                    tmr_d   = '0;
                    byte_d  = byte_q + 4'd1;
                end else if (tmr_q == ACK_M1) begin
                    commit = 1'b1;
                end
            end
            DESELECT: begin
                if (tmr_q == SETUP_M1) begin
                    if (pad_q == LAST_PAD) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = SELECT;
                        pad_d   = pad_q + PAD_W'(1);
                    end
                end
            end
            default: state_d = BOOT;
        endcase

        if (state_d == SELECT && state_q != SELECT) begin
            tmr_d    = '0;
            byte_d   = '0;
            nbytes_d = 4'd9;  // longest frame until the ID byte sets the length
            att_d    = ~(NUM_PADS'(1) << pad_d);
        end

        // All per-pad results change together on entry to DESELECT.
        if (commit) begin
            state_d = DESELECT;
            tmr_d   = '0;
            att_d   = '1;
            if (commit_ok) begin
                button_d[pad_q*16 +: 16] = btn_buf_d;
                present_d[pad_q]         = 1'b1;
                pad_analog_d[pad_q]      = is_analog_q;
                if (is_analog_q) begin
                    analog_d[pad_q*32 +: 32] = ana_buf_d;
                end
            end else begin
                button_d[pad_q*16 +: 16] = 16'hFFFF;
                analog_d[pad_q*32 +: 32] = 32'h80808080;
                present_d[pad_q]         = 1'b0;
                pad_analog_d[pad_q]      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            frame_cnt_q  <= '0;
            tmr_q        <= '0;
            pad_q        <= '0;
            byte_q       <= '0;
            nbytes_q     <= 4'd9;
            btn_buf_q    <= 16'hFFFF;
            ana_buf_q    <= 32'h80808080;
            is_analog_q  <= 1'b0;
            att_q        <= '1;
            present_q    <= '0;
            pad_analog_q <= '0;
            button_q     <= '1;
            analog_q     <= {NUM_PADS{32'h80808080}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            tmr_q        <= tmr_d;
            pad_q        <= pad_d;
            byte_q       <= byte_d;
            nbytes_q     <= nbytes_d;
            btn_buf_q    <= btn_buf_d;
            ana_buf_q    <= ana_buf_d;
            is_analog_q  <= is_analog_d;
            att_q        <= att_d;
            present_q    <= present_d;
            pad_analog_q <= pad_analog_d;
            button_q     <= button_d;
            analog_q     <= analog_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign att          = att_q;
    assign button_state = button_q;
    assign analog_state = analog_q;
    assign pad_present  = present_q;
    assign pad_analog   = pad_analog_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_psx_multi_console.sv
// tb/tb_psx_multi_console.sv - self-checking bench for psx_multi_console
module tb_psx_multi_console;
    localparam int NP = 2;
    localparam int CD = 2;
    localparam int BT = 50;
    localparam int PP = 2000;
    localparam int AT = 20;
    localparam int AS = 4;

    logic clk = 1'b0;
    logic rst, data, ack;
    logic psx_clk, cmd, frame_done;
    logic [NP-1:0]    att, pad_present, pad_analog;
    logic [16*NP-1:0] button_state;
    logic [32*NP-1:0] analog_state;

    always #5 clk = ~clk;

    psx_multi_console #(
        .NUM_PADS(NP), .CLK_DIV(CD), .BOOT_TIME(BT),
        .POLL_PERIOD(PP), .ACK_TIMEOUT(AT), .ATT_SETUP(AS)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .ack(ack),
        .psx_clk(psx_clk), .cmd(cmd), .att(att),
        .button_state(button_state), .analog_state(analog_state),
        .pad_present(pad_present), .pad_analog(pad_analog),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [31:0] btn;
        logic [63:0] ana;
        logic [1:0]  pres;
        logic [1:0]  anl;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model state
    logic [7:0] reply [NP][9];
    logic [8:0] ack_en [NP];
    int  pm_active = 0, pm_pad = 0, pm_byte = 0, pm_bit = 0, pm_t0 = 0;
    int  pm_dur [NP];
    int  pm_falls [NP];
    int  last_fall = 0, ack_wait = 0, ack_low = 0;
    int  att_err = 0, per_err = 0, cmd_err = 0, cmd_bytes = 0, n_done = 0;
    int  t_start[$];
    logic prev_psx = 1'b1;
    logic [7:0] cmd_cap, rb, exp_cmd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, expv);
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
    endtask

    // bytes: byte i at [8*i +: 8]; acks: bit i = pad acks after byte i
    task automatic set_reply(input int p, input logic [71:0] bytes, input logic [8:0] acks);
        for (int i = 0; i < 9; i++) reply[p][i] = bytes[8*i +: 8];
        ack_en[p] = acks;
    endtask

    task automatic measure_boot(input string tag);
        int n;
        n = 0;
        while (att == '1 && n < BT + 20) begin
            @(negedge clk);
            n++;
        end
        check_range(tag, n, BT, BT + 2);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        exp_t e;
        n = 0;
        while (!frame_done && n < 3 * PP) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_done"}, 64'(frame_done), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_button_state"}, 64'(button_state), 64'(e.btn));
            check({tag, "_analog_state"}, analog_state, e.ana);
            check({tag, "_pad_present"}, 64'(pad_present), 64'(e.pres));
            check({tag, "_pad_analog"}, 64'(pad_analog), 64'(e.anl));
        end else begin
            check({tag, "_scoreboard_entry"}, 64'd0, 64'd1);
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(frame_done), 64'd0);
    endtask

    // Pad model: reacts on the falling clk edge, away from DUT updates.
    initial begin
        data = 1'b1;
        ack  = 1'b1;
        forever begin
            @(negedge clk);
            if (frame_done) n_done++;
            if ($countones(~att) > 1) att_err++;
            if (att == '1) begin
                if (pm_active != 0) pm_dur[pm_pad] = cyc - pm_t0;
                pm_active = 0;
                data = 1'b1;
                ack = 1'b1;
                ack_wait = 0;
                ack_low = 0;
            end else begin
                if (pm_active == 0) begin
                    pm_active = 1;
                    pm_pad = att[0] ? 1 : 0;
                    pm_byte = 0;
                    pm_bit = 0;
                    pm_t0 = cyc;
                    pm_falls[pm_pad] = 0;
                    if (pm_pad == 0) t_start.push_back(cyc);
                end
                if (prev_psx && !psx_clk) begin
                    if (pm_bit != 0 && cyc - last_fall != 2 * CD) per_err++;
                    last_fall = cyc;
                    pm_falls[pm_pad]++;
                    rb = (pm_byte < 9) ? reply[pm_pad][pm_byte] : 8'hFF;
                    data = rb[pm_bit];
                end
                if (!prev_psx && psx_clk) begin
                    if (cyc - last_fall != CD) per_err++;
                    cmd_cap[pm_bit] = cmd;
                    if (pm_bit == 7) begin
                        exp_cmd = (pm_byte == 0) ? 8'h01 : (pm_byte == 1) ? 8'h42 : 8'h00;
                        if (cmd_cap != exp_cmd) cmd_err++;
                        cmd_bytes++;
                        if (pm_byte < 9 && ack_en[pm_pad][pm_byte]) ack_wait = CD + 3;
                        pm_byte++;
                        pm_bit = 0;
                    end else begin
                        pm_bit++;
                    end
                end
                if (ack_wait > 0) begin
                    ack_wait--;
                    if (ack_wait == 0) ack_low = 3;
                end
                if (ack_low > 0) begin
                    ack = 1'b0;
                    ack_low--;
                end else begin
                    ack = 1'b1;
                end
            end
            prev_psx = psx_clk;
        end
    end

    localparam logic [71:0] DIG0  = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h7F, 8'h5A, 8'h41, 8'hFF};
    localparam logic [71:0] ANA1  = {8'h40, 8'h30, 8'h20, 8'h10, 8'hFF, 8'hFF, 8'h5A, 8'h73, 8'hFF};
    localparam logic [71:0] ANA2  = {8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'hEE, 8'h5A, 8'h73, 8'hFF};
    localparam logic [71:0] BADMK = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h7F, 8'h00, 8'h41, 8'hFF};
    localparam logic [71:0] DIG1  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'h5A, 8'h41, 8'hFF};

    initial begin
        int n;
        rst = 1'b1;
        set_reply(0, DIG0, 9'h00F);
        set_reply(1, ANA1, 9'h0FF);
        repeat (3) @(negedge clk);
        check("rst_psx_clk", 64'(psx_clk), 64'd1);
        check("rst_cmd", 64'(cmd), 64'd1);
        check("rst_att", 64'(att), 64'h3);
        check("rst_button_state", 64'(button_state), 64'hFFFF_FFFF);
        check("rst_analog_state", analog_state, 64'h8080_8080_8080_8080);
        check("rst_pad_present", 64'(pad_present), 64'd0);
        check("rst_pad_analog", 64'(pad_analog), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);

        // Frame 1: digital pad 0, analog pad 1
        sb.push_back('{btn: 32'hFFFF_FE7F, ana: 64'h4030_2010_8080_8080, pres: 2'b11, anl: 2'b10});
        rst = 1'b0;
        measure_boot("boot_first_poll");
        wait_frame("f1");

        // Frame 2: pad 0 never acks, pad 1 analog with new sticks
        set_reply(0, DIG0, 9'h000);
        set_reply(1, ANA2, 9'h0FF);
        sb.push_back('{btn: 32'hFFEE_FFFF, ana: 64'h4433_2211_8080_8080, pres: 2'b10, anl: 2'b10});
        wait_frame("f2");
        check_range("f2_ack_timeout_att_low", pm_dur[0], AS + 16 * CD + AT, AS + 16 * CD + AT + 3);

        // Frame 3: pad 0 bad marker, pad 1 digital keeps its old sticks
        set_reply(0, BADMK, 9'h00F);
        set_reply(1, DIG1, 9'h00F);
        sb.push_back('{btn: 32'h5AA5_FFFF, ana: 64'h4433_2211_8080_8080, pres: 2'b10, anl: 2'b00});
        wait_frame("f3");
        check("f3_bad_marker_clocks", 64'(pm_falls[0]), 64'd24);

        if (t_start.size() >= 3) begin
            check("frame_period_1", 64'(t_start[1] - t_start[0]), 64'(PP));
            check("frame_period_2", 64'(t_start[2] - t_start[1]), 64'(PP));
        end else begin
            check("frame_starts_seen", 64'(t_start.size()), 64'd3);
        end

        // Frame 4 is cut by reset during byte 3 of pad 0
        set_reply(0, DIG0, 9'h00F);
        n = 0;
        while (!(pm_active != 0 && pm_pad == 0 && pm_byte == 3 && !psx_clk) && n < 3 * PP) begin
            @(negedge clk);
            n++;
        end
        check("rst_point_reached", 64'(n < 3 * PP), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_att", 64'(att), 64'h3);
        check("midrst_psx_clk", 64'(psx_clk), 64'd1);
        check("midrst_button_state", 64'(button_state), 64'hFFFF_FFFF);
        check("midrst_analog_state", analog_state, 64'h8080_8080_8080_8080);
        check("midrst_pad_present", 64'(pad_present), 64'd0);
        check("midrst_pad_analog", 64'(pad_analog), 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        measure_boot("boot_after_rst");

        // Frame 5: both pads digital after reset; analog_state stays at default
        sb.push_back('{btn: 32'h5AA5_FE7F, ana: 64'h8080_8080_8080_8080, pres: 2'b11, anl: 2'b00});
        wait_frame("f5");

        check("att_one_hot_violations", 64'(att_err), 64'd0);
        check("psx_clk_period_errors", 64'(per_err), 64'd0);
        check("cmd_byte_errors", 64'(cmd_err), 64'd0);
        check("cmd_bytes_seen", 64'(cmd_bytes > 0), 64'd1);
        check("frame_done_pulses", 64'(n_done), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
